id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded operands and control from ID each cycle and presents them to EX. Its rs_ex, rt_ex and control outputs drive the EX-stage forwarding logic and ALU muxes.
- Stalls IF/ID on a load-use hazard and inserts a bubble.
- Kills the ID instruction on an EX-resolved branch/jump flush, and holds everything on a downstream hold request.

---
 rtl/id_ex_stage_reg_if.sv | 67 ++++++
 rtl/id_ex_stage_reg.sv | 113 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decoded ID-side fields in, registered EX-side fields and stall controls out.
// The slave modport is the stage register itself; master is whatever drives ID and consumes EX.
interface id_ex_stage_reg_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 4
);
  logic                    hold_in;
  logic                    flush_ex;
  logic [4:0]              rs_id;
  logic [4:0]              rt_id;
  logic [4:0]              rd_id;
  logic                    uses_rs_id;
  logic                    uses_rt_id;
  logic [DATA_WIDTH-1:0]   read_data1_id;
  logic [DATA_WIDTH-1:0]   read_data2_id;
  logic [DATA_WIDTH-1:0]   imm_id;
  logic [DATA_WIDTH-1:0]   pc_plus4_id;
  logic                    reg_write_id;
  logic                    mem_read_id;
  logic                    mem_write_id;
  logic                    mem_to_reg_id;
  logic                    alu_src_id;
  logic                    reg_dst_id;
  logic [ALU_OP_WIDTH-1:0] alu_op_id;
  logic                    reg_write_wb;
  logic [4:0]              write_reg_wb;
  logic [DATA_WIDTH-1:0]   write_data_wb;

  logic [4:0]              rs_ex;
  logic [4:0]              rt_ex;
  logic [4:0]              rd_ex;
  logic [DATA_WIDTH-1:0]   read_data1_ex;
  logic [DATA_WIDTH-1:0]   read_data2_ex;
  logic [DATA_WIDTH-1:0]   imm_ex;
  logic [DATA_WIDTH-1:0]   pc_plus4_ex;
  logic                    reg_write_ex;
  logic                    mem_read_ex;
  logic                    mem_write_ex;
  logic                    mem_to_reg_ex;
  logic                    alu_src_ex;
  logic                    reg_dst_ex;
  logic [ALU_OP_WIDTH-1:0] alu_op_ex;
  logic                    valid_ex;
  logic                    pc_write;
  logic                    if_id_write;
  logic                    load_use_stall;

  modport slave (
    input  hold_in, flush_ex, rs_id, rt_id, rd_id, uses_rs_id, uses_rt_id,
           read_data1_id, read_data2_id, imm_id, pc_plus4_id,
           reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id, alu_src_id, reg_dst_id,
           alu_op_id, reg_write_wb, write_reg_wb, write_data_wb,
    output rs_ex, rt_ex, rd_ex, read_data1_ex, read_data2_ex, imm_ex, pc_plus4_ex,
           reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex, alu_src_ex, reg_dst_ex,
           alu_op_ex, valid_ex, pc_write, if_id_write, load_use_stall
  );

  modport master (
    output hold_in, flush_ex, rs_id, rt_id, rd_id, uses_rs_id, uses_rt_id,
           read_data1_id, read_data2_id, imm_id, pc_plus4_id,
           reg_write_id, mem_read_id, mem_write_id, mem_to_reg_id, alu_src_id, reg_dst_id,
           alu_op_id, reg_write_wb, write_reg_wb, write_data_wb,
    input  rs_ex, rt_ex, rd_ex, read_data1_ex, read_data2_ex, imm_ex, pc_plus4_ex,
           reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex, alu_src_ex, reg_dst_ex,
           alu_op_ex, valid_ex, pc_write, if_id_write, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles and downstream hold.
// Optional macro ID_EX_RF_BYPASS_EN forwards the WB write into captured operands.
module id_ex_stage_reg #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  id_ex_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic [4:0]              rs;
    logic [4:0]              rt;
    logic [4:0]              rd;
    logic [DATA_WIDTH-1:0]   rd1;
    logic [DATA_WIDTH-1:0]   rd2;
    logic [DATA_WIDTH-1:0]   imm;
    logic [DATA_WIDTH-1:0]   pc4;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    alu_src;
    logic                    reg_dst;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    valid;
  } ex_t;

  ex_t  ex_q, ex_d, cap;
  logic hz;
  logic stall;

  // Only a real load in EX whose destination is read by ID (and is not $0) forces a stall.
  always_comb begin
    hz = ex_q.mem_read && ex_q.valid && (ex_q.rt != 5'd0) &&
         ((bus.uses_rs_id && (ex_q.rt == bus.rs_id)) ||
          (bus.uses_rt_id && (ex_q.rt == bus.rt_id)));
    stall = hz && !bus.flush_ex && !bus.hold_in;
  end

  always_comb begin
    cap            = '0;
    cap.rs         = bus.rs_id;
    cap.rt         = bus.rt_id;
    cap.rd         = bus.rd_id;
    cap.rd1        = bus.read_data1_id;
    cap.rd2        = bus.read_data2_id;
    cap.imm        = bus.imm_id;
    cap.pc4        = bus.pc_plus4_id;
    cap.reg_write  = bus.reg_write_id;
    cap.mem_read   = bus.mem_read_id;
    cap.mem_write  = bus.mem_write_id;
    cap.mem_to_reg = bus.mem_to_reg_id;
    cap.alu_src    = bus.alu_src_id;
    cap.reg_dst    = bus.reg_dst_id;
    cap.alu_op     = bus.alu_op_id;
    cap.valid      = 1'b1;
`ifdef ID_EX_RF_BYPASS_EN
    // Register file reads the old value in the WB-write cycle, so patch it here.
    if (bus.reg_write_wb && (bus.write_reg_wb != 5'd0) && (bus.write_reg_wb == bus.rs_id)) begin
      cap.rd1 = bus.write_data_wb;
    end
    if (bus.reg_write_wb && (bus.write_reg_wb != 5'd0) && (bus.write_reg_wb == bus.rt_id)) begin
      cap.rd2 = bus.write_data_wb;
    end
`endif
  end

`ifndef ID_EX_RF_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{bus.reg_write_wb, bus.write_reg_wb, bus.write_data_wb};
`endif

  always_comb begin
    ex_d = ex_q;
    if (bus.hold_in) begin
      ex_d = ex_q;
    end else if (bus.flush_ex || hz) begin
      ex_d = '0;
    end else begin
      ex_d = cap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.rs_ex          = ex_q.rs;
  assign bus.rt_ex          = ex_q.rt;
  assign bus.rd_ex          = ex_q.rd;
  assign bus.read_data1_ex  = ex_q.rd1;
  assign bus.read_data2_ex  = ex_q.rd2;
  assign bus.imm_ex         = ex_q.imm;
  assign bus.pc_plus4_ex    = ex_q.pc4;
  assign bus.reg_write_ex   = ex_q.reg_write;
  assign bus.mem_read_ex    = ex_q.mem_read;
  assign bus.mem_write_ex   = ex_q.mem_write;
  assign bus.mem_to_reg_ex  = ex_q.mem_to_reg;
  assign bus.alu_src_ex     = ex_q.alu_src;
  assign bus.reg_dst_ex     = ex_q.reg_dst;
  assign bus.alu_op_ex      = ex_q.alu_op;
  assign bus.valid_ex       = ex_q.valid;
  assign bus.load_use_stall = stall;
  assign bus.pc_write       = !bus.hold_in && !stall;
  assign bus.if_id_write    = !bus.hold_in && !stall;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized and directed bench for id_ex_stage_reg against a cycle-level reference model.
module tb_id_ex_stage_reg;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] d1, d2, imm, pc4;
    logic          rw, mr, mw, m2r, asrc, rdst;
    logic [AW-1:0] op;
    logic          v;
  } ex_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  ex_t  m;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(AW)) bus ();

  id_ex_stage_reg #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ex_t dut_ex();
    ex_t e;
    e = '{rs: bus.rs_ex, rt: bus.rt_ex, rd: bus.rd_ex, d1: bus.read_data1_ex,
          d2: bus.read_data2_ex, imm: bus.imm_ex, pc4: bus.pc_plus4_ex, rw: bus.reg_write_ex,
          mr: bus.mem_read_ex, mw: bus.mem_write_ex, m2r: bus.mem_to_reg_ex,
          asrc: bus.alu_src_ex, rdst: bus.reg_dst_ex, op: bus.alu_op_ex, v: bus.valid_ex};
    return e;
  endfunction

  // Load in EX feeding a register the ID instruction reads.
  function automatic logic model_hz();
    if (!(m.v && m.mr) || m.rt == 0) return 1'b0;
    return (bus.uses_rs_id && bus.rs_id == m.rt) || (bus.uses_rt_id && bus.rt_id == m.rt);
  endfunction

  function automatic logic [DW-1:0] model_operand(input logic [4:0] src, input logic [DW-1:0] rf);
`ifdef ID_EX_RF_BYPASS_EN
    if (bus.reg_write_wb && bus.write_reg_wb != 0 && bus.write_reg_wb == src) return bus.write_data_wb;
`endif
    return rf;
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    if (bus.hold_in) return m;
    if (bus.flush_ex || model_hz()) return '0;
    n = '{rs: bus.rs_id, rt: bus.rt_id, rd: bus.rd_id,
          d1: model_operand(bus.rs_id, bus.read_data1_id),
          d2: model_operand(bus.rt_id, bus.read_data2_id),
          imm: bus.imm_id, pc4: bus.pc_plus4_id, rw: bus.reg_write_id, mr: bus.mem_read_id,
          mw: bus.mem_write_id, m2r: bus.mem_to_reg_id, asrc: bus.alu_src_id,
          rdst: bus.reg_dst_id, op: bus.alu_op_id, v: 1'b1};
    return n;
  endfunction

  task automatic set_idle();
    bus.hold_in = 0; bus.flush_ex = 0;
    bus.rs_id = 0; bus.rt_id = 0; bus.rd_id = 0; bus.uses_rs_id = 0; bus.uses_rt_id = 0;
    bus.read_data1_id = 0; bus.read_data2_id = 0; bus.imm_id = 0; bus.pc_plus4_id = 0;
    bus.reg_write_id = 0; bus.mem_read_id = 0; bus.mem_write_id = 0; bus.mem_to_reg_id = 0;
    bus.alu_src_id = 0; bus.reg_dst_id = 0; bus.alu_op_id = 0;
    bus.reg_write_wb = 0; bus.write_reg_wb = 0; bus.write_data_wb = 0;
  endtask

  task automatic rand_id();
    bus.rs_id = 5'($urandom_range(0, 3)); bus.rt_id = 5'($urandom_range(0, 3));
    bus.rd_id = 5'($urandom); bus.uses_rs_id = 1'($urandom); bus.uses_rt_id = 1'($urandom);
    bus.read_data1_id = $urandom; bus.read_data2_id = $urandom;
    bus.imm_id = $urandom; bus.pc_plus4_id = $urandom;
    bus.reg_write_id = 1'($urandom); bus.mem_read_id = ($urandom_range(0, 1) == 0);
    bus.mem_write_id = 1'($urandom); bus.mem_to_reg_id = 1'($urandom);
    bus.alu_src_id = 1'($urandom); bus.reg_dst_id = 1'($urandom); bus.alu_op_id = 4'($urandom);
    bus.reg_write_wb = 1'($urandom); bus.write_reg_wb = 5'($urandom_range(0, 3));
    bus.write_data_wb = $urandom;
  endtask

  // Called at posedge+1 with inputs applied; checks comb outputs, then the captured state.
  task automatic step(input string tag);
    logic hz_e, st_e;
    ex_t  nxt;
    #1;
    hz_e = model_hz();
    st_e = hz_e && !bus.flush_ex && !bus.hold_in;
    chk_eq({tag, "_stall"}, 256'(bus.load_use_stall), 256'(st_e));
    chk_eq({tag, "_pcw"}, 256'({bus.pc_write, bus.if_id_write}),
           256'({2{!bus.hold_in && !st_e}}));
    nxt = model_next();
    @(posedge clk);
    m = nxt;
    #1;
    chk_eq({tag, "_ex"}, 256'(dut_ex()), 256'(m));
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    m = '0;
    #1;
    chk_eq("rst_ex", 256'(dut_ex()), 256'(0));
    chk_eq("rst_pcw", 256'(bus.pc_write), 256'(1));
    @(posedge clk);
    #1 reset = 1'b0;

    // Load $8 <- mem, then dependent add: one stall cycle, then capture.
    bus.mem_read_id = 1; bus.rt_id = 8; bus.reg_write_id = 1; bus.mem_to_reg_id = 1;
    step("ld");
    set_idle();
    bus.rs_id = 8; bus.uses_rs_id = 1; bus.rt_id = 9; bus.uses_rt_id = 1; bus.rd_id = 10;
    bus.reg_write_id = 1; bus.read_data1_id = 32'h1111;
    #1 chk_eq("lu_stall", 256'(bus.load_use_stall), 256'(1));
    chk_eq("lu_pcw", 256'(bus.pc_write), 256'(0));
    step("lu1");
    chk_eq("lu_bubble", 256'(bus.valid_ex), 256'(0));
    step("lu2");
    chk_eq("lu_rs", 256'({bus.valid_ex, bus.rs_ex}), 256'({1'b1, 5'd8}));

    // Load targeting $0, and unused matching field: no stall.
    set_idle(); bus.mem_read_id = 1; bus.rt_id = 0; step("ld0");
    set_idle(); bus.rs_id = 0; bus.uses_rs_id = 1; step("ld0_use");
    chk_eq("ld0_cap", 256'(bus.valid_ex), 256'(1));
    set_idle(); bus.mem_read_id = 1; bus.rt_id = 8; step("ld8");
    set_idle(); bus.rs_id = 8; bus.uses_rs_id = 0; step("nouse");
    chk_eq("nouse_cap", 256'(bus.valid_ex), 256'(1));

    // Hazard with simultaneous flush: no stall, bubble.
    set_idle(); bus.mem_read_id = 1; bus.rt_id = 8; step("ld8b");
    set_idle(); bus.rs_id = 8; bus.uses_rs_id = 1; bus.flush_ex = 1; step("hzfl");
    chk_eq("hzfl_v", 256'(bus.valid_ex), 256'(0));

    // Hold with flush for three cycles, then release.
    set_idle(); bus.reg_write_id = 1; bus.imm_id = 32'hCAFE; step("pre_hold");
    for (int i = 0; i < 3; i++) begin
      rand_id(); bus.hold_in = 1; bus.flush_ex = 1; step("hold");
      chk_eq("hold_imm", 256'(bus.imm_ex), 256'(32'hCAFE));
    end
    bus.hold_in = 0; step("unhold");
    chk_eq("unhold_v", 256'(bus.valid_ex), 256'(0));

    // WB bypass into rt operand.
    set_idle(); bus.reg_write_wb = 1; bus.write_reg_wb = 5; bus.write_data_wb = 32'hDEADBEEF;
    bus.rt_id = 5; bus.read_data2_id = 32'h1; step("byp");
`ifdef ID_EX_RF_BYPASS_EN
    chk_eq("byp_d2", 256'(bus.read_data2_ex), 256'(32'hDEADBEEF));
`else
    chk_eq("byp_d2", 256'(bus.read_data2_ex), 256'(32'h1));
`endif
    bus.write_reg_wb = 0; bus.rt_id = 0; step("byp0");
    chk_eq("byp0_d2", 256'(bus.read_data2_ex), 256'(32'h1));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      bus.hold_in = ($urandom_range(0, 7) == 0);
      bus.flush_ex = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    // Async reset mid-cycle with a live writing instruction in EX.
    set_idle(); bus.reg_write_id = 1; step("pre_rst");
    #2 reset = 1'b1;
    #1;
    chk_eq("mid_rst_ex", 256'(dut_ex()), 256'(0));
    chk_eq("mid_rst_pcw", 256'(bus.pc_write), 256'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    m = '0;
    set_idle(); bus.rs_id = 3; step("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
